// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter between the core MEM stage
// and the debug loader port.
package dmem_arbiter_pkg;

    localparam int DM_ADDRESS_DEF    = 9;
    localparam int DATA_W_DEF        = 32;
    localparam int MAX_CORE_WINS_DEF = 4;
    localparam int CNT_W             = 3;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_DBG
    } grant_e;

    // Field widths follow the default memory geometry.
    typedef struct packed {
        logic                      rd;
        logic                      wr;
        logic [DM_ADDRESS_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [2:0]                funct3;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Counts consecutive contested core wins so the debug port cannot starve.
// Saturates at MAX_CORE_WINS; clears on a debug grant or an idle debug port.
module starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_CORE_WINS = MAX_CORE_WINS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dbg_valid,
    input  logic             core_win,
    input  logic             dbg_win,
    output logic [CNT_W-1:0] win_cnt
);

    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (dbg_win || !dbg_valid) begin
            win_cnt_d = '0;
        end else if (core_win && (win_cnt_q < CNT_W'(MAX_CORE_WINS))) begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    assign win_cnt = win_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core MEM stage has priority, the debug
// loader is guaranteed a slot after MAX_CORE_WINS contested core grants.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS    = DM_ADDRESS_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_CORE_WINS = MAX_CORE_WINS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err_sticky
);

    logic             core_req;
    logic             contested;
    grant_e           gnt;
    mem_req_t         req;
    logic [CNT_W-1:0] win_cnt;

    logic              rvalid_q;
    logic              rvalid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              err_q;
    logic              err_d;

    always_comb begin
        core_req  = core_rd | core_wr;
        contested = core_req & dbg_valid;
        gnt       = GNT_NONE;
        if (!reset) begin
            if (contested) begin
                gnt = (win_cnt == CNT_W'(MAX_CORE_WINS)) ? GNT_DBG : GNT_CORE;
            end else if (core_req) begin
                gnt = GNT_CORE;
            end else if (dbg_valid) begin
                gnt = GNT_DBG;
            end
        end
    end

    // A simultaneous core read+write is demoted to a plain write.
    always_comb begin
        req = '0;
        case (gnt)
            GNT_CORE: begin
                req.rd     = core_rd & ~core_wr;
                req.wr     = core_wr;
                req.addr   = core_addr;
                req.wdata  = core_wdata;
                req.funct3 = core_funct3;
            end
            GNT_DBG: begin
                req.rd     = ~dbg_we;
                req.wr     = dbg_we;
                req.addr   = dbg_addr;
                req.wdata  = dbg_wdata;
                req.funct3 = dbg_funct3;
            end
            default: req = '0;
        endcase
    end

    assign mem_rd     = req.rd;
    assign mem_wr     = req.wr;
    assign mem_addr   = req.addr;
    assign mem_wdata  = req.wdata;
    assign mem_funct3 = req.funct3;

    assign core_rdata = (gnt == GNT_CORE) ? mem_rdata : '0;
    assign core_stall = core_req & (gnt == GNT_DBG);
    assign dbg_ready  = (gnt == GNT_DBG);

    always_comb begin
        rvalid_d = (gnt == GNT_DBG) & ~dbg_we;
        rdata_d  = rvalid_d ? mem_rdata : rdata_q;
        err_d    = err_q | (core_rd & core_wr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;
    assign err_sticky = err_q;

    starve_counter #(
        .MAX_CORE_WINS(MAX_CORE_WINS)
    ) u_starve_counter (
        .clk      (clk),
        .reset    (reset),
        .dbg_valid(dbg_valid),
        .core_win (contested & (gnt == GNT_CORE)),
        .dbg_win  (gnt == GNT_DBG),
        .win_cnt  (win_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural word memory
// and a read-response scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd, core_wr;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        dbg_valid, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_funct3;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic        err_sticky;

    logic [31:0] mem [0:127];
    logic [31:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_funct3(dbg_funct3),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .err_sticky(err_sticky)
    );

    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;

    // Read-response scoreboard
    always @(negedge clk) begin
        if (!reset && dbg_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected got rdata=%h expected no response", dbg_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dbg_rdata !== e) begin
                    failures++;
                    $display("FAIL dbg_rdata got=%h expected=%h", dbg_rdata, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_funct3 = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_funct3 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        core_rd = 1; core_addr = 9'h010;
        dbg_valid = 1; dbg_addr = 9'h020;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, dbg_ready, core_stall} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got rd,wr,rdy,stall=%b expected=0000",
                     {mem_rd, mem_wr, dbg_ready, core_stall});
        end
        checks++;
        if ({dbg_rvalid, err_sticky, dbg_rdata} !== 34'h0) begin
            failures++;
            $display("FAIL reset_regs got rvalid=%b err=%b rdata=%h expected 0",
                     dbg_rvalid, err_sticky, dbg_rdata);
        end
        idle_inputs();
        step();
        reset = 0;
        step();
    endtask

    task automatic test_idle();
        idle_inputs();
        dbg_addr = 9'h1fc; dbg_wdata = 32'hffff_ffff; dbg_funct3 = 3'b111;
        core_addr = 9'h0f0; core_wdata = 32'h5555_aaaa; core_funct3 = 3'b101;
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3} !== 46'h0) begin
            failures++;
            $display("FAIL idle_bus got rd=%b wr=%b addr=%h wdata=%h f3=%b expected 0",
                     mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_core_load();
        mem[4] = 32'hDEAD_BEEF;
        core_rd = 1; core_addr = 9'h010; core_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if (core_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL core_load_data got=%h expected=deadbeef", core_rdata);
        end
        checks++;
        if ({core_stall, dbg_ready, mem_rd} !== 3'b001) begin
            failures++;
            $display("FAIL core_load_ctrl got stall,rdy,mem_rd=%b expected=001",
                     {core_stall, dbg_ready, mem_rd});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_dbg_write_read();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 9'h020;
        dbg_wdata = 32'h1234_5678; dbg_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if ({dbg_ready, mem_wr, mem_rd, mem_addr, mem_funct3} !== {3'b110, 9'h020, 3'b010}) begin
            failures++;
            $display("FAIL dbg_write_ctrl got rdy=%b wr=%b rd=%b addr=%h f3=%b",
                     dbg_ready, mem_wr, mem_rd, mem_addr, mem_funct3);
        end
        step();
        dbg_we = 0; dbg_wdata = 0;
        exp_q.push_back(32'h1234_5678);
        @(negedge clk);
        checks++;
        if ({dbg_ready, mem_rd, dbg_rvalid} !== 3'b110) begin
            failures++;
            $display("FAIL dbg_read_ctrl got rdy,rd,rvalid=%b expected=110",
                     {dbg_ready, mem_rd, dbg_rvalid});
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({dbg_ready, dbg_rvalid} !== 2'b01) begin
            failures++;
            $display("FAIL dbg_read_resp got rdy,rvalid=%b expected=01", {dbg_ready, dbg_rvalid});
        end
        step();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL dbg_rvalid_pulse got=%b expected=0", dbg_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            step();
            dbg_valid = 1; dbg_we = 0; dbg_addr = 9'(i * 4);
            exp_q.push_back(mem[i]);
            @(negedge clk);
            checks++;
            if (dbg_ready !== 1'b1 || dbg_rvalid !== (i > 0)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got rdy=%b rvalid=%b", i, dbg_ready, dbg_rvalid);
            end
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last got rvalid=%b expected=1", dbg_rvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got rvalid=%b expected=0", dbg_rvalid);
        end
    endtask

    task automatic test_rdwr_err();
        step();
        core_rd = 1; core_wr = 1; core_addr = 9'h004;
        core_wdata = 32'hA5A5_0F0F; core_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if ({mem_wr, mem_rd, err_sticky} !== 3'b100) begin
            failures++;
            $display("FAIL rdwr_ctrl got wr,rd,err=%b expected=100", {mem_wr, mem_rd, err_sticky});
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (err_sticky !== 1'b1 || mem[1] !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL rdwr_effect got err=%b mem=%h expected 1 a5a50f0f", err_sticky, mem[1]);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if (err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL err_hold got=%b expected=1", err_sticky);
        end
    endtask

    task automatic test_reset_mid_grant();
        step();
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h010;
        reset = 1;
        @(negedge clk);
        checks++;
        if ({dbg_ready, mem_rd, core_stall} !== 3'b000) begin
            failures++;
            $display("FAIL rst_grant got rdy,rd,stall=%b expected=000", {dbg_ready, mem_rd, core_stall});
        end
        step();
        reset = 0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({dbg_rvalid, err_sticky, dbg_rdata} !== 34'h0) begin
            failures++;
            $display("FAIL rst_after got rvalid=%b err=%b rdata=%h expected 0",
                     dbg_rvalid, err_sticky, dbg_rdata);
        end
    endtask

    task automatic test_contention();
        int cnt;
        logic exp_d;
        cnt = 0;
        mem[16] = 32'hCAFE_0001;
        for (int i = 0; i < 15; i++) begin
            step();
            core_rd = 1; core_addr = 9'h010; core_funct3 = 3'b010;
            dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h040;
            exp_d = (cnt == 4);
            if (exp_d) exp_q.push_back(mem[16]);
            @(negedge clk);
            checks++;
            if (core_stall !== exp_d || dbg_ready !== exp_d ||
                core_rdata !== (exp_d ? 32'h0 : 32'hDEAD_BEEF)) begin
                failures++;
                $display("FAIL contend_cycle%0d got stall=%b rdy=%b rdata=%h expected dbg=%b",
                         i, core_stall, dbg_ready, core_rdata, exp_d);
            end
            cnt = exp_d ? 0 : cnt + 1;
        end
        step();
        idle_inputs();
        step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_idle();
        test_core_load();
        test_dbg_write_read();
        test_back_to_back();
        test_rdwr_err();
        test_reset_mid_grant();
        test_contention();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_responses got pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DM_ADDRESS, default 9: data-memory byte-address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter MAX_CORE_WINS, default 4, legal range 1..7: consecutive contested core grants before the debug port is forced a grant.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 core_rd / core_wr  in  1 / 1  read / write request from the pipeline MEM stage (level).
REQ-007 core_addr / core_wdata / core_funct3  in  DM_ADDRESS / DATA_W / 3  core access address, store data, size code.
REQ-008 core_rdata / core_stall  out  DATA_W / 1  load data / freeze EX-MEM and earlier stages.
REQ-009 dbg_valid / dbg_we  in  1 / 1  debug-loader request valid / 1 = write.
REQ-010 dbg_addr / dbg_wdata / dbg_funct3  in  DM_ADDRESS / DATA_W / 3  debug address, data, size code.
REQ-011 dbg_ready / dbg_rvalid / dbg_rdata  out  1 / 1 / DATA_W  accept strobe / read-response valid / read-response data.
REQ-012 mem_rd / mem_wr / mem_addr / mem_wdata / mem_funct3  out  1/1/DM_ADDRESS/DATA_W/3  to data memory.
REQ-013 mem_rdata  in  DATA_W  combinational read data; writes commit at the clk edge.
REQ-014 err_sticky  out  1  set on an illegal core request.

Function
REQ-015 Core request = core_rd | core_wr; contested = core request & dbg_valid.
REQ-016 Grant decision is combinational each cycle: uncontested requester wins; contested goes to core unless win_cnt == MAX_CORE_WINS, in which case dbg wins.
REQ-017 win_cnt increments on each contested core grant, clears on any dbg grant, and clears in any cycle dbg_valid = 0.
REQ-018 Core grant: mem_* driven from core_*; core_rdata = mem_rdata in the same cycle; core_stall = 0.
REQ-019 Dbg grant: mem_* driven from dbg_*; mem_rd = ~dbg_we; mem_wr = dbg_we; dbg_ready = 1 in that cycle only.
REQ-020 core_stall = 1 exactly when a core request is present and dbg is granted; core inputs are held stable by the pipeline while stalled.
REQ-021 Dbg read: dbg_rdata registers mem_rdata at the grant edge; dbg_rvalid = 1 for exactly the following cycle.
REQ-022 Dbg write: no response; dbg_rvalid stays 0.
REQ-023 Back-to-back dbg reads produce one rvalid pulse per accepted read, with no gap cycle.
REQ-024 No requester: mem_rd = mem_wr = 0; mem_addr, mem_wdata and mem_funct3 = 0.
REQ-025 core_rd & core_wr asserted together: treated as a write only; err_sticky set on the next edge and held until reset.
REQ-026 dbg_valid deasserted before dbg_ready: request dropped, no memory access, win_cnt cleared.
REQ-027 win_cnt never exceeds MAX_CORE_WINS and never wraps.

Reset
REQ-028 While reset = 1: win_cnt = 0, dbg_rvalid = 0, dbg_rdata = 0, err_sticky = 0, no grant issued, mem_rd = mem_wr = 0, dbg_ready = 0, core_stall = 0.
REQ-029 A dbg read accepted in the cycle reset rises produces no rvalid pulse.

Structure
REQ-030 The shared package holds the mem_req_t struct {rd, wr, addr, wdata, funct3}, the grant_e enum {GNT_NONE, GNT_CORE, GNT_DBG}, and the MAX_CORE_WINS default.
REQ-031 One sub-module, starve_counter, holds win_cnt and its saturation and clear logic.

Verification
REQ-032 Core-only load, addr 0x010, memory 0xDEADBEEF -> core_rdata = 0xDEADBEEF in the same cycle; core_stall = 0; dbg_ready = 0.
REQ-033 Dbg-only write 0x12345678 to 0x020, then dbg read 0x020 -> dbg_ready pulses once per request; dbg_rvalid 1 cycle after the read grant with dbg_rdata = 0x12345678.
REQ-034 Core and dbg requesting continuously, MAX_CORE_WINS = 4 -> grant pattern C,C,C,C,D repeating; core_stall high only on D cycles.
REQ-035 Core rd and wr asserted together at addr 0x004 -> memory write occurs; err_sticky = 1 from the next cycle until reset.
REQ-036 Reset asserted in the cycle a dbg read is granted -> dbg_rvalid stays 0; win_cnt = 0; all outputs at reset values.
REQ-037 Three back-to-back dbg reads at 0x000, 0x004, 0x008 with no core traffic -> three consecutive rvalid cycles with the matching data in order.
